// File: rtl/adc_sched_pkg.sv
// ---------------------------------------------------------------------------
// adc_sched_pkg
//   Shared definitions for the ADC sample scheduler:
//     - DATA_W       : width of an MCP3002 result / output sample
//     - CONV_CYCLES  : clk cycles for one driver transaction (0.9 MHz SCK at
//                      27 MHz); the scheduler period must exceed this
//     - state_t      : scheduler FSM state encoding
//     - offset_to_signed() : offset-binary to two's-complement conversion
// ---------------------------------------------------------------------------
package adc_sched_pkg;

  localparam int DATA_W      = 10;
  localparam int CONV_CYCLES = 480;

  // Fixed encodings so the state can be probed and decoded by checkers.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_PUSH      = 3'd4
  } state_t;

  // Offset binary (0 = most negative) to two's complement: flip the MSB.
  function automatic logic [DATA_W-1:0] offset_to_signed(input logic [DATA_W-1:0] raw);
    return {~raw[DATA_W-1], raw[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Synchronous FIFO, depth 2**AW, zero read latency (rd_data is the head
//   word whenever empty=0, and reads as zero while empty).
//   Ports:
//     clk, rst_n   clock, async active-low reset (flushes the FIFO)
//     wr_en        push request; accepted when not full, or when full and a
//                  pop happens in the same cycle
//     wr_data      word to push
//     rd_en        pop request; ignored while empty (a push into an empty
//                  FIFO becomes visible on the next cycle)
//     rd_data      head word
//     full, empty  status flags
// ---------------------------------------------------------------------------
module sample_fifo
  import adc_sched_pkg::*;
#(
  parameter int W  = DATA_W,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // When full, a simultaneous pop frees the head slot, so the push may land.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// adc_sample_scheduler
//   Paces the MCP3002 driver at SAMPLE_RATE: one conversion per period tick,
//   converts each offset-binary result to two's complement and queues it in a
//   2**FIFO_AW deep FIFO feeding the OFDM receive front end.
//
//   Ports:
//     clk, rst_n            system clock, async active-low reset
//     run                   level: 1 = sample continuously
//     adc_enable            1-cycle start pulse to the driver
//     adc_clear_available   1-cycle clear of the driver's result flag
//     adc_data[9:0]         driver result, offset binary
//     adc_available         driver result-ready flag
//     smp_data[9:0]         signed sample at the FIFO head
//     smp_valid, smp_ready  output stream handshake
//     overrun               sticky: sample dropped (FIFO full) or tick missed
//     timeout_err           sticky: driver never reported data
//     busy                  FSM not idle
//     overrun_cnt[15:0]     only with ADC_SCHED_OVERRUN_CNT_EN: saturating
//                           count of dropped or missed samples
//
//   Stream handshake: smp_valid is high whenever the FIFO holds a sample and
//   smp_data is that sample; a transfer happens on every rising clk edge with
//   smp_valid & smp_ready both high. smp_valid never depends on smp_ready.
//
//   Configuration macro: ADC_SCHED_OVERRUN_CNT_EN adds overrun_cnt.
// ---------------------------------------------------------------------------
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SAMPLE_RATE = 40_000,
  parameter int FIFO_AW     = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              adc_enable,
  output logic              adc_clear_available,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_available,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              overrun,
  output logic              timeout_err,
  output logic              busy
`ifdef ADC_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]       overrun_cnt
`endif
);

  localparam int PERIOD = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  // FSM
  state_t state;
  state_t next_state;

  // Counters and per-conversion state
  logic [CNT_W-1:0]  period_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tick;
  logic              run_q;
  logic              run_rise;
  logic              abort;
  logic [DATA_W-1:0] cap_data;

  // Decoded FSM actions
  logic              clear_flags;
  logic              capture;
  logic              push_req;
  logic              set_timeout;
  logic              data_seen;
  logic              missed_tick;
  logic              drop;

  // FIFO
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign run_rise = run && !run_q;

  // The tick is defined only while scheduling; the counter is parked at 0 in idle.
  assign tick = (state != S_IDLE) && (period_cnt == CNT_W'(PERIOD - 1));

  // The driver's flag is cleared in S_START but that clear lands during the
  // first S_WAIT_DATA cycle, so a stale flag there must be ignored.
  assign data_seen = adc_available && (wait_cnt != WAIT_W'(1));

  // A tick that arrives while a conversion is still in flight cannot start one.
  assign missed_tick = tick && ((state == S_START) || (state == S_WAIT_DATA) || (state == S_PUSH));

  assign pop  = smp_ready && !fifo_empty;
  assign drop = push_req && fifo_full && !pop;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and decoded actions
  // -------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    clear_flags = 1'b0;
    capture     = 1'b0;
    push_req    = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_rise) begin
          clear_flags = 1'b1;
          next_state  = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!run) begin
          next_state = S_IDLE;
        end else if (tick) begin
          next_state = S_START;
        end
      end
      S_START: begin
        // The driver has been started; it cannot be aborted, so always wait.
        next_state = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (data_seen) begin
          capture    = 1'b1;
          next_state = (abort || !run) ? S_IDLE : S_PUSH;
        end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
          set_timeout = 1'b1;
          next_state  = (abort || !run) ? S_IDLE : S_WAIT_TICK;
        end
      end
      S_PUSH: begin
        push_req   = 1'b1;
        next_state = run ? S_WAIT_TICK : S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign adc_enable          = (state == S_START);
  assign adc_clear_available = (state == S_START);
  assign busy                = (state != S_IDLE);

  // -------------------------------------------------------------------------
  // Run edge detect, period counter, wait counter, abort latch, capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (state == S_IDLE) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Loaded with 1 as S_WAIT_DATA is entered, so it equals the number of
  // cycles spent waiting; it stops at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_START) begin
      wait_cnt <= WAIT_W'(1);
    end else if ((state == S_WAIT_DATA) && (wait_cnt != WAIT_W'(TIMEOUT))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Remembers that run dropped while the conversion was in flight, so the
  // result is discarded even if run comes back before the data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort <= 1'b0;
    end else if (state == S_START) begin
      abort <= !run;
    end else if (state == S_WAIT_DATA) begin
      abort <= abort || !run;
    end else begin
      abort <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data <= '0;
    end else if (capture) begin
      cap_data <= offset_to_signed(adc_data);
    end
  end

  // -------------------------------------------------------------------------
  // Sticky status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (clear_flags) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (missed_tick || drop) begin
        overrun <= 1'b1;
      end
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef ADC_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (clear_flags) begin
      overrun_cnt <= '0;
    end else if ((missed_tick || drop) && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  sample_fifo #(
    .W  (DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_req),
    .wr_data (cap_data),
    .rd_en   (smp_ready),
    .rd_data (smp_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign smp_valid = !fifo_empty;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_scheduler
//   Bench for adc_sample_scheduler with a behavioural MCP3002 model. The
//   model queues the expected signed sample when it delivers a result; the
//   monitor pops and compares on each stream transfer.
//   Builds with or without ADC_SCHED_OVERRUN_CNT_EN.
// ---------------------------------------------------------------------------
module tb_adc_sample_scheduler;

  localparam int PERIOD  = 675;
  localparam int CONV    = 480;
  localparam int TIMEOUT = 1023;
  localparam int DEPTH   = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // -------------------------------------------------------------------------
  // DUT
  // -------------------------------------------------------------------------
  logic       run = 1'b0;
  logic       adc_enable;
  logic       adc_clear_available;
  logic [9:0] adc_data;
  logic       adc_available;
  logic [9:0] smp_data;
  logic       smp_valid;
  logic       smp_ready = 1'b1;
  logic       overrun;
  logic       timeout_err;
  logic       busy;
`ifdef ADC_SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  adc_sample_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .run                 (run),
    .adc_enable          (adc_enable),
    .adc_clear_available (adc_clear_available),
    .adc_data            (adc_data),
    .adc_available       (adc_available),
    .smp_data            (smp_data),
    .smp_valid           (smp_valid),
    .smp_ready           (smp_ready),
    .overrun             (overrun),
    .timeout_err         (timeout_err),
    .busy                (busy)
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt         (overrun_cnt)
`endif
  );

  // -------------------------------------------------------------------------
  // Scoreboard state and checker
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural MCP3002 driver: result ready CONV cycles after the enable
  // cycle; flag held until cleared.
  // -------------------------------------------------------------------------
  logic [9:0] model_vals[$];
  logic [9:0] model_default = 10'h3FF;
  logic [9:0] model_v;
  bit         model_silent = 1'b0;
  int         model_rem = 0;
  int         exp_drops = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_available <= 1'b0;
      adc_data      <= '0;
      model_rem     = 0;
    end else begin
      if (adc_clear_available) adc_available <= 1'b0;
      if (adc_enable) begin
        if (!model_silent) model_rem = CONV - 1;
      end else if (model_rem > 0) begin
        model_rem--;
        if (model_rem == 0) begin
          model_v = (model_vals.size() != 0) ? model_vals.pop_front() : model_default;
          adc_data      <= model_v;
          adc_available <= 1'b1;
          // Expected sample: the offset-binary code minus 512, as 10-bit two's complement.
          if (run) begin
            if (exp_q.size() >= DEPTH) exp_drops++;
            else exp_q.push_back(model_v - 10'd512);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: stream transfers and enable pulses
  // -------------------------------------------------------------------------
  int enable_count = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (adc_enable) enable_count++;
      if (smp_valid && smp_ready) begin
        if (exp_q.size() != 0) check_eq("smp_data", 32'(smp_data), 32'(exp_q.pop_front()));
        else check_eq("unexpected_sample_queue_size", 32'(exp_q.size()), 32'd1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    smp_ready = 1'b1;
    model_silent = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    model_vals.delete();
    exp_drops = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next adc_enable (bounded) and returns the cycle it was seen in.
  task automatic wait_enable(input int budget, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!adc_enable && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("enable_seen", 32'(adc_enable), 32'd1);
    c = int'(cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_adc_enable"}, 32'(adc_enable), 32'd0);
    check_eq({tag, "_adc_clear"}, 32'(adc_clear_available), 32'd0);
    check_eq({tag, "_smp_valid"}, 32'(smp_valid), 32'd0);
    check_eq({tag, "_smp_data"}, 32'(smp_data), 32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int run_c, c1, c2, c3, c_to, n, e0;

    // Test 0: reset state
    do_reset();
    check_all_zero("reset");

    // Test 1: pacing with full-scale code 3FF -> +511
    model_default = 10'h3FF;
    run = 1'b1;
    run_c = int'(cyc);
    wait_enable(PERIOD + 10, c1);
    // run is sampled on the next edge; the first tick follows PERIOD cycles later.
    check_eq("first_enable_latency", 32'(c1 - run_c), 32'(PERIOD + 1));
    check_eq("clear_with_enable", 32'(adc_clear_available), 32'd1);
    @(negedge clk);
    check_eq("enable_one_cycle", 32'(adc_enable), 32'd0);
    wait_enable(PERIOD + 10, c2);
    check_eq("enable_interval_1", 32'(c2 - c1), 32'(PERIOD));
    wait_enable(PERIOD + 10, c3);
    check_eq("enable_interval_2", 32'(c3 - c2), 32'(PERIOD));
    wait_cycles(CONV + 5);
    check_eq("t1_queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("t1_overrun", 32'(overrun), 32'd0);

    // Test 2: code 000 -> -512 (200), code 200 -> 0
    do_reset();
    model_vals.push_back(10'h000);
    model_vals.push_back(10'h200);
    run = 1'b1;
    wait_enable(PERIOD + 10, c1);
    wait_enable(PERIOD + 10, c2);
    wait_cycles(CONV + 5);
    check_eq("t2_queue_drained", 32'(exp_q.size()), 32'd0);
    run = 1'b0;

    // Test 3: consumer stalled for 20 periods, FIFO fills, 4 samples dropped
    do_reset();
    smp_ready = 1'b0;
    for (int i = 0; i < 24; i++) model_vals.push_back(10'($urandom_range(0, 1023)));
    run = 1'b1;
    for (int i = 0; i < 17; i++) wait_enable(PERIOD + 10, c1);
    check_eq("t3_valid_held", 32'(smp_valid), 32'd1);
    check_eq("t3_no_overrun_at_16", 32'(overrun), 32'd0);
    wait_cycles(CONV + 3);
    check_eq("t3_overrun_after_17", 32'(overrun), 32'd1);
    for (int i = 0; i < 3; i++) wait_enable(PERIOD + 10, c1);
    wait_cycles(CONV + 3);
    check_eq("t3_drops_modelled", 32'(exp_drops), 32'd4);
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    check_eq("t3_overrun_cnt", 32'(overrun_cnt), 32'd4);
`endif
    wait_enable(PERIOD + 10, c1);
    smp_ready = 1'b1;
    wait_cycles(DEPTH + 4);
    check_eq("t3_fifo_drained", 32'(exp_q.size()), 32'd0);
    check_eq("t3_valid_low", 32'(smp_valid), 32'd0);
    run = 1'b0;
    wait_cycles(CONV + 5);

    // Test 4: driver never answers -> timeout, missed tick, restart on next tick
    do_reset();
    model_silent = 1'b1;
    model_default = 10'h155;
    run = 1'b1;
    wait_enable(PERIOD + 10, c1);
    n = 0;
    while (!timeout_err && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    c_to = int'(cyc);
    check_eq("t4_timeout_seen", 32'(timeout_err), 32'd1);
    check_eq("t4_timeout_latency", 32'(c_to - c1), 32'(TIMEOUT + 1));
    check_eq("t4_missed_tick_overrun", 32'(overrun), 32'd1);
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    check_eq("t4_overrun_cnt", 32'(overrun_cnt), 32'd1);
`endif
    model_silent = 1'b0;
    wait_enable(2 * PERIOD, c2);
    check_eq("t4_restart_interval", 32'(c2 - c1), 32'(2 * PERIOD));

    // Test 5: run drops mid-conversion -> result discarded, idle, no restart
    wait_cycles(100);
    run = 1'b0;
    wait_cycles(100);
    check_eq("t5_busy_during_conv", 32'(busy), 32'd1);
    wait_cycles(CONV - 200 + 5);
    check_eq("t5_idle_after_data", 32'(busy), 32'd0);
    check_eq("t5_no_push", 32'(smp_valid), 32'd0);
    e0 = enable_count;
    wait_cycles(2 * PERIOD);
    check_eq("t5_no_enable_idle", 32'(enable_count - e0), 32'd0);
    check_eq("t5_timeout_still_set", 32'(timeout_err), 32'd1);
    run = 1'b1;
    run_c = int'(cyc);
    wait_cycles(2);
    check_eq("t5_timeout_cleared", 32'(timeout_err), 32'd0);
    check_eq("t5_overrun_cleared", 32'(overrun), 32'd0);
`ifdef ADC_SCHED_OVERRUN_CNT_EN
    check_eq("t5_overrun_cnt_cleared", 32'(overrun_cnt), 32'd0);
`endif
    wait_enable(PERIOD + 10, c1);
    check_eq("t5_restart_latency", 32'(c1 - run_c), 32'(PERIOD + 1));
    wait_cycles(CONV + 5);
    check_eq("t5_sample_delivered", 32'(exp_q.size()), 32'd0);

    // Test 6: reset in the middle of S_WAIT_DATA with samples held
    smp_ready = 1'b0;
    wait_enable(PERIOD + 10, c1);
    wait_cycles(CONV + 5);
    check_eq("t6_sample_held", 32'(smp_valid), 32'd1);
    wait_enable(PERIOD + 10, c1);
    wait_cycles(50);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_reset");
    exp_q.delete();
    model_vals.delete();
    smp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_c = int'(cyc);
    wait_enable(PERIOD + 10, c1);
    check_eq("t6_restart_latency", 32'(c1 - run_c), 32'(PERIOD + 1));
    wait_cycles(CONV + 5);
    check_eq("t6_sample_after_restart", 32'(exp_q.size()), 32'd0);
    check_eq("t6_flags_clean", 32'({overrun, timeout_err}), 32'd0);
    run = 1'b0;
    wait_cycles(PERIOD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
